// File: rtl/add_ca_pkg.sv
// Shared constants and helpers for the add_ca carry-lookahead adder.
// Width must be a positive multiple of the group size.
package add_ca_pkg;

  localparam int GROUP_SIZE    = 4;
  localparam int DEFAULT_WIDTH = 4;

  function automatic int groupCount(input int width);
    return width / GROUP_SIZE;
  endfunction

endpackage

// File: rtl/add_ca_cla4.sv
// The cla4 group: a 4-bit carry-lookahead slice. It produces sum bits plus the
// group propagate/generate pair, which the top-level lookahead unit consumes.
module add_ca_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every internal carry is a flat sum-of-products of p/g and ci, with no ripple.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);

  assign s = w_p ^ w_c;
  assign P = &w_p;
  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/add_ca.sv
// Registered carry-lookahead adder: {cout, q} = a + b + cin, one cycle after the
// operands are presented with in_valid. Groups of 4 bits are joined by lookahead.
module add_ca
  import add_ca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             cout
);

  localparam int NGROUPS = groupCount(WIDTH);

  generate
    if (WIDTH <= 0 || (WIDTH % GROUP_SIZE) != 0) begin : g_badWidth
      $error("add_ca: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [NGROUPS-1:0] w_groupP;
  logic [NGROUPS-1:0] w_groupG;
  logic [NGROUPS:0]   w_groupCarry;
  logic [WIDTH-1:0]   w_sum;

  logic               r_valid;
  logic [WIDTH-1:0]   r_q;
  logic               r_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_group
      add_ca_cla4 u_cla4 (
        .a  (a[gi*GROUP_SIZE +: GROUP_SIZE]),
        .b  (b[gi*GROUP_SIZE +: GROUP_SIZE]),
        .ci (w_groupCarry[gi]),
        .s  (w_sum[gi*GROUP_SIZE +: GROUP_SIZE]),
        .P  (w_groupP[gi]),
        .G  (w_groupG[gi])
      );
    end
  endgenerate

  // Second lookahead level: each group carry-in is the OR over lower groups of
  // G[j] gated by the AND of all P above j, plus cin gated by every P below.
  logic w_acc;
  logic w_prod;
  always_comb begin
    w_groupCarry    = '0;
    w_acc           = 1'b0;
    w_prod          = 1'b1;
    w_groupCarry[0] = cin;
    for (int k = 1; k <= NGROUPS; k++) begin
      w_acc  = 1'b0;
      w_prod = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_groupG[j]);
        w_prod = w_prod & w_groupP[j];
      end
      w_groupCarry[k] = w_acc | (w_prod & cin);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_q    <= w_sum;
        r_cout <= w_groupCarry[NGROUPS];
      end
    end
  end

  assign out_valid = r_valid;
  assign q         = r_q;
  assign cout      = r_cout;

endmodule

// File: tb/tb_add_ca.sv
// Self-checking bench for add_ca at WIDTH=4 and WIDTH=16: directed table,
// exhaustive 4-bit sweep and randomized traffic against an arithmetic model.
module tb_add_ca;

  logic        clk;
  logic        rst;

  logic        inValid4, cin4;
  logic [3:0]  a4, b4;
  logic        outValid4, cout4;
  logic [3:0]  q4;

  logic        inValid16, cin16;
  logic [15:0] a16, b16;
  logic        outValid16, cout16;
  logic [15:0] q16;

  int total;
  int bad;

  // Behavioural expectation: last captured sum and whether last edge captured.
  logic [4:0]  m4Sum;
  logic        m4Valid;
  logic [16:0] m16Sum;
  logic        m16Valid;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] q;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[11];

  add_ca #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(outValid4), .q(q4), .cout(cout4)
  );

  add_ca #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(outValid16), .q(q16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive both DUTs, advance the model by the addition rule, then sample #1 after the edge.
  task automatic applyStimulus(input logic v4, input logic [3:0] x4, input logic [3:0] y4,
                               input logic c4, input logic v16, input logic [15:0] x16,
                               input logic [15:0] y16, input logic c16);
    inValid4  = v4;  a4  = x4;  b4  = y4;  cin4  = c4;
    inValid16 = v16; a16 = x16; b16 = y16; cin16 = c16;
    if (rst) begin
      m4Sum = '0; m4Valid = 1'b0; m16Sum = '0; m16Valid = 1'b0;
    end else begin
      if (v4)  m4Sum  = 5'(int'(x4) + int'(y4) + int'(c4));
      if (v16) m16Sum = 17'(int'(x16) + int'(y16) + int'(c16));
      m4Valid  = v4;
      m16Valid = v16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel4(input string name);
    checkOutput({name, "_q4"},    17'(q4),        17'(m4Sum[3:0]));
    checkOutput({name, "_cout4"}, 17'(cout4),     17'(m4Sum[4]));
    checkOutput({name, "_ov4"},   17'(outValid4), 17'(m4Valid));
  endtask

  task automatic checkModel16(input string name);
    checkOutput({name, "_q16"},    17'(q16),        17'(m16Sum[15:0]));
    checkOutput({name, "_cout16"}, 17'(cout16),     17'(m16Sum[16]));
    checkOutput({name, "_ov16"},   17'(outValid16), 17'(m16Valid));
  endtask

  initial begin
    logic [3:0]  ta, tb;
    logic        tc, tv;
    logic [15:0] wa, wb;
    logic        wc, wv;
    total = 0;
    bad   = 0;
    m4Sum = '0; m4Valid = 1'b0; m16Sum = '0; m16Valid = 1'b0;

    tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'h1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'hf, 4'hf, 1'b0, 4'he, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 4'hf, 4'hf, 1'b1, 4'hf, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'hf, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'ha, 4'h7, 1'b1, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'hc, 4'hc, 1'b0, 4'h8, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1};

    // Reset, load a non-zero result, then reset again with a valid operation present.
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h9, 4'h9, 1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1);
    checkModel4("preload");
    checkModel16("preload");
    rst = 1'b1;
    applyStimulus(1'b1, 4'hf, 4'hf, 1'b1, 1'b1, 16'hffff, 16'hffff, 1'b1);
    checkOutput("reset_q4",     17'(q4),         17'h0);
    checkOutput("reset_cout4",  17'(cout4),      17'h0);
    checkOutput("reset_ov4",    17'(outValid4),  17'h0);
    checkOutput("reset_q16",    17'(q16),        17'h0);
    checkOutput("reset_cout16", 17'(cout16),     17'h0);
    checkOutput("reset_ov16",   17'(outValid16), 17'h0);
    rst = 1'b0;

    // Directed table: first entry is captured on the first edge after reset.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 16'h0, 16'h0, 1'b0);
      checkOutput($sformatf("tbl%0d_q", i),    17'(q4),        17'(tbl[i].q));
      checkOutput($sformatf("tbl%0d_cout", i), 17'(cout4),     17'(tbl[i].co));
      checkOutput($sformatf("tbl%0d_ov", i),   17'(outValid4), 17'(tbl[i].ov));
    end

    // Wide directed: inter-group carries.
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'hffff, 16'h0001, 1'b0);
    checkOutput("w16_q",    17'(q16),    17'h0000);
    checkOutput("w16_cout", 17'(cout16), 17'h1);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'hffff, 16'h0000, 1'b1);
    checkModel16("w16_prop");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'h00ff, 16'h0001, 1'b0);
    checkModel16("w16_grp1");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'hffff, 16'hffff, 1'b1);
    checkModel16("w16_max");

    // Exhaustive 4-bit sweep, back-to-back.
    for (int i = 0; i < 512; i++) begin
      ta = i[3:0];
      tb = i[7:4];
      tc = i[8];
      applyStimulus(1'b1, ta, tb, tc, 1'b0, 16'h0, 16'h0, 1'b0);
      checkModel4($sformatf("exh%0d", i));
    end

    // Randomized traffic with gaps in in_valid on both widths.
    for (int i = 0; i < 300; i++) begin
      tv = ($urandom_range(0, 3) != 0);
      ta = 4'($urandom);
      tb = 4'($urandom);
      tc = 1'($urandom);
      wv = ($urandom_range(0, 3) != 0);
      wa = 16'($urandom);
      wb = 16'($urandom);
      wc = 1'($urandom);
      applyStimulus(tv, ta, tb, tc, wv, wa, wb, wc);
      checkModel4($sformatf("rnd%0d", i));
      checkModel16($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
